id_issue_ctrl: RTL
==================

# id_issue_ctrl

Issue controller for the decode (ID) stage of the five-stage RV32I pipeline. It owns the ID→EX valid/allowin handshake, tracks in-flight loads in a per-register scoreboard to produce load-use stalls, squashes the fetch path on taken branches, and sequences ECALL trap entry through a drain-then-redirect state machine. It sits beside the decoder, consumes its decoded register fields, and drives `stall_flag`, `ds_allowin` and the PC redirect.

## Interface
- `LOAD_LAT`, 2: cycles from load issue into EX until its data is forwardable to ID. Legal range is 1..7.
- `DRAIN_CYCLES`, 3: cycles waited after ECALL issue before redirecting, so older instructions retire.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: ID holds a valid instruction.
- `id_rs1`, `id_rs2` in 5 each: source register indices.
- `id_rs1_used`, `id_rs2_used` in 1 each: the instruction reads that source.
- `id_rd` in 5, `id_rd_wen` in 1: destination register and its write enable.
- `id_mem_re` in 1: the instruction is a load (any width).
- `id_ecall` in 1: the instruction is ECALL.
- `es_allowin` in 1: EX can accept this cycle.
- `br_taken` in 1, `br_target` in 32: taken branch or jump resolved in EX.
- `mtvec` in 32: trap vector from the CSR file.
- `id_to_es_valid` out 1: ID issues to EX this cycle.
- `ds_allowin` out 1: ID can accept a new instruction from IF.
- `stall_flag` out 1: load-use hazard is active.
- `flush_if` out 1: kill the IF/ID contents.
- `pc_redirect_valid` out 1, `pc_redirect` out 32: next-PC override.
- `trap_busy` out 1: trap sequencer is not IDLE.

## Operation
- **Issue fire:** `fire = id_valid & es_allowin & ~stall_flag & ~br_taken & (state==IDLE)`. `id_to_es_valid = fire`.
- **ds_allowin:** `ds_allowin = ~id_valid | fire`. The signal is forced to 0 when state is DRAIN or REDIRECT.
- **Scoreboard:** 31 counters, one per x1..x31, each 3 bits. x0 never tracks.
  - On `fire & id_mem_re & id_rd_wen & id_rd!=0`, cnt[id_rd] loads `LOAD_LAT-1`.
  - Every other nonzero counter decrements by 1 each cycle.
  - If a load re-targets a register whose counter is already nonzero, the new load value wins. There is no decrement that cycle.
- **stall_flag:** `stall_flag = id_valid & ((id_rs1_used & id_rs1!=0 & cnt[id_rs1]!=0) | (id_rs2_used & id_rs2!=0 & cnt[id_rs2]!=0))`.
- **Branch:** while `br_taken` is high:
  - `flush_if=1`, `pc_redirect_valid=1`, `pc_redirect=br_target`.
  - ID does not fire, so the ID instruction is squashed.
  - `br_taken` takes priority over the stall and over an ECALL in ID.
- **Trap FSM:**
  - IDLE→DRAIN when `fire & id_ecall`. The drain counter loads `DRAIN_CYCLES-1`.
  - DRAIN decrements to 0, then goes to REDIRECT.
  - REDIRECT lasts 1 cycle: `pc_redirect_valid=1`, `pc_redirect=mtvec`, `flush_if=1`. It then returns to IDLE.
  - `br_taken` is ignored outside IDLE. Only instructions older than the ECALL can be in flight, and those have already resolved.
- **Redirect priority:** REDIRECT outranks `br_taken`.
- **Reset values:** all counters 0, state IDLE, drain counter 0. Consequently `stall_flag=0`, `trap_busy=0`, `pc_redirect_valid=0`, `flush_if=0`, `pc_redirect=0`. `id_to_es_valid=0`, `ds_allowin=1` when `id_valid=0`.
- **Reset mid-operation:** asserting reset during DRAIN or with pending counters clears everything immediately. No redirect is emitted.

## Timing
- All outputs are combinational from current state and inputs. Counters and FSM update on posedge `clk`.
- **Load-use bubble count** for a dependent directly behind a load is `LOAD_LAT-1`. With `LOAD_LAT=2`: load fires at cycle t, dependent stalls at t+1, issues at t+2.
- **Independent instruction** behind a load: no bubble.
- **ECALL redirect:** ECALL fires at cycle t. `pc_redirect_valid` with `mtvec` is high at cycle `t+DRAIN_CYCLES+1` for exactly 1 cycle. `trap_busy` is high from t+1 through that cycle.
- **Backpressure:** `es_allowin=0` holds ID. Counters still decrement, so a stall can resolve under backpressure.

## Configuration
- `ID_LOAD_SCOREBOARD_EN` defined: full 31-entry scoreboard as above, honoring `LOAD_LAT`.
- Undefined:
  - The scoreboard is replaced by a single `prev_load` flag plus a `prev_rd` register, captured on fire of a load and cleared on any non-load fire or idle cycle.
  - Stall is limited to the instruction immediately behind the load, always 1 bubble.
  - `LOAD_LAT` is ignored.

## Test plan
- **Load-use:** `lw x5` then `add x6,x5,x1`, `LOAD_LAT=2`. Expect `stall_flag=1` for exactly 1 cycle, the add issues at t+2, and `cnt[5]=0` afterwards.
- **x0 and unused sources:** `lw x0` then `add x1,x0,x0`, and `lw x7` then `lui x7`. Expect no stall in either case.
- **Branch squash:** `br_taken=1`, `br_target=0x0000_0100`, with a stalled dependent in ID. Expect `flush_if=1`, `pc_redirect=0x100` for 1 cycle, `id_to_es_valid=0`.
- **ECALL:** ECALL fires at t, `mtvec=0x8000_0000`, `DRAIN_CYCLES=3`. Expect `ds_allowin=0` from t+1 to t+4, redirect to 0x8000_0000 at t+4 only, then IDLE at t+5.
- **Back-to-back loads:** `lw x3` then `lw x3` then `add x4,x3,x3`. Expect a single bubble (counter reload), no double count.
- **Reset in DRAIN:** assert `rst_n=0` at t+2 after ECALL. Expect state IDLE, `trap_busy=0`, and no redirect after release.

Source files
------------

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: ID->EX handshake, load-use hazard detection,
// branch squash and ECALL drain/redirect sequencing.
// Build option: ID_LOAD_SCOREBOARD_EN selects the 31-entry load scoreboard;
// otherwise a single previous-load tracker gives a fixed one-bubble stall.
module id_issue_ctrl #(
    parameter int LOAD_LAT     = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_wen,
    input  logic        id_mem_re,
    input  logic        id_ecall,
    input  logic        es_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] mtvec,
    output logic        id_to_es_valid,
    output logic        ds_allowin,
    output logic        stall_flag,
    output logic        flush_if,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect,
    output logic        trap_busy
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } trap_state_t;

    // Out-of-range parameters are rejected at elaboration.
    if ((LOAD_LAT < 1) || (LOAD_LAT > 7) || (DRAIN_CYCLES < 1)) begin : g_param_check
        $error("id_issue_ctrl: illegal LOAD_LAT or DRAIN_CYCLES");
    end

    trap_state_t      state_r;
    trap_state_t      state_nxt_s;
    logic [DCW-1:0]   drain_cnt_r;
    logic [DCW-1:0]   drain_cnt_nxt_s;

    logic             idle_s;
    logic             redirect_s;
    logic             branch_s;
    logic             fire_s;
    logic             load_issue_s;
    logic [31:0]      busy_s;

    assign idle_s       = (state_r == ST_IDLE);
    assign redirect_s   = (state_r == ST_REDIRECT);
    assign branch_s     = idle_s & br_taken;
    assign fire_s       = id_valid & es_allowin & ~stall_flag & ~br_taken & idle_s;
    assign load_issue_s = fire_s & id_mem_re & id_rd_wen & (id_rd != 5'd0);

`ifdef ID_LOAD_SCOREBOARD_EN
    logic [2:0] cnt_r [1:31];

    // Per-register load countdown: a new load reloads, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                cnt_r[i] <= 3'd0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (load_issue_s && (id_rd == 5'(i))) begin
                    cnt_r[i] <= 3'(LOAD_LAT - 1);
                end else if (cnt_r[i] != 3'd0) begin
                    cnt_r[i] <= cnt_r[i] - 3'd1;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Flatten the counters into a per-register pending-load vector.
    always_comb begin
        busy_s = 32'd0;
        for (int i = 1; i < 32; i++) begin
            busy_s[i] = (cnt_r[i] != 3'd0);
        end
    end
`else
    logic       prev_load_r;
    logic [4:0] prev_rd_r;

    // Remember only the load issued last cycle; any other cycle forgets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_load_r <= 1'b0;
            prev_rd_r   <= 5'd0;
        end else if (load_issue_s) begin
            prev_load_r <= 1'b1;
            prev_rd_r   <= id_rd;
        end else begin
            prev_load_r <= 1'b0;
            prev_rd_r   <= prev_rd_r;
        end
    end

    // Single pending-load bit at the tracked destination.
    always_comb begin
        busy_s            = 32'd0;
        busy_s[prev_rd_r] = prev_load_r;
    end
`endif

    // Load-use hazard on either used, nonzero source.
    always_comb begin
        stall_flag = id_valid &
                     ((id_rs1_used & (id_rs1 != 5'd0) & busy_s[id_rs1]) |
                      (id_rs2_used & (id_rs2 != 5'd0) & busy_s[id_rs2]));
    end

    // Trap sequencer state and drain counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= {DCW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

    // Trap sequencer next state: ECALL issue -> drain older work -> one redirect cycle.
    always_comb begin
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s && id_ecall) begin
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = DCW'(DRAIN_CYCLES - 1);
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == {DCW{1'b0}}) begin
                    state_nxt_s     = ST_REDIRECT;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r - {{(DCW-1){1'b0}}, 1'b1};
                end
            end
            ST_REDIRECT: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                drain_cnt_nxt_s = {DCW{1'b0}};
            end
        endcase
    end

    // Handshake and redirect outputs; the trap redirect outranks any branch.
    always_comb begin
        id_to_es_valid    = fire_s;
        ds_allowin        = idle_s & (~id_valid | fire_s);
        trap_busy         = ~idle_s;
        flush_if          = redirect_s | branch_s;
        pc_redirect_valid = redirect_s | branch_s;
        if (redirect_s) begin
            pc_redirect = mtvec;
        end else if (branch_s) begin
            pc_redirect = br_target;
        end else begin
            pc_redirect = 32'd0;
        end
    end

endmodule
